// File: rtl/cpu_clk_pkg.sv
// Shared constants and types for the CPU clock-enable generator.
// Mode encodings, default divisor and the operation decode used by cpu_clken_gen.
package cpu_clk_pkg;

    localparam logic [1:0] MODE_RUN  = 2'b00;
    localparam logic [1:0] MODE_STEP = 2'b01;
    localparam logic [1:0] MODE_HALT = 2'b10;

    localparam int unsigned DEFAULT_RESET_DIV = 1;
    localparam int unsigned ONE_HZ_DIV        = 100000000;

    // Per-cycle operation after resolving load priority; 2'b11 mode folds into HALT.
    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_RUN  = 2'b01,
        OP_STEP = 2'b10,
        OP_HALT = 2'b11
    } op_e;

    function automatic op_e decode_op(input logic load, input logic [1:0] mode);
        op_e op;
        if (load) begin
            op = OP_LOAD;
        end else begin
            case (mode)
                MODE_RUN:  op = OP_RUN;
                MODE_STEP: op = OP_STEP;
                default:   op = OP_HALT;
            endcase
        end
        return op;
    endfunction

endpackage

// File: rtl/cpu_clken_gen_rise_detect.sv
// Rising-edge detector: one-cycle-wide rise_po when sig_pi goes from 0 to 1.
// Also suitable for debounced board buttons.
module rise_detect (
    input  logic clk_pi,
    input  logic reset_pi,
    input  logic sig_pi,
    output logic rise_po
);

    logic sig_prev;

    always_ff @(posedge clk_pi or posedge reset_pi) begin
        if (reset_pi) begin
            sig_prev <= 1'b0;
        end else begin
            sig_prev <= sig_pi;
        end
    end

    assign rise_po = sig_pi & ~sig_prev;

endmodule

// File: rtl/cpu_clken_gen.sv
// Programmable CPU clock-enable generator with RUN / STEP / HALT modes and a pulse counter.
// All outputs come straight from registers; a divisor of 0 is always stored as 1.
module cpu_clken_gen
    import cpu_clk_pkg::*;
#(
    parameter int unsigned              DIV_WIDTH = 32,
    parameter logic [DIV_WIDTH-1:0]     RESET_DIV = DIV_WIDTH'(DEFAULT_RESET_DIV),
    parameter int unsigned              CNT_WIDTH = 16
) (
    input  logic                 clk_pi,
    input  logic                 reset_pi,
    input  logic [1:0]           mode_pi,
    input  logic [DIV_WIDTH-1:0] div_pi,
    input  logic                 div_load_pi,
    input  logic                 step_pi,
    output logic                 clk_en_po,
    output logic [DIV_WIDTH-1:0] div_po,
    output logic [CNT_WIDTH-1:0] en_count_po
);

    localparam logic [DIV_WIDTH-1:0] DIV_ONE     = DIV_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0] RESET_DIV_Q = (RESET_DIV == '0) ? DIV_ONE : RESET_DIV;

    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic                 en_q, en_d;
    logic [CNT_WIDTH-1:0] en_count_q;
    logic                 step_rise;
    op_e                  op;

    rise_detect u_step_rise (
        .clk_pi   (clk_pi),
        .reset_pi (reset_pi),
        .sig_pi   (step_pi),
        .rise_po  (step_rise)
    );

    // div_q is never zero, so div_q - 1 cannot wrap.
    always_comb begin
        op    = decode_op(div_load_pi, mode_pi);
        div_d = div_q;
        cnt_d = cnt_q;
        en_d  = 1'b0;
        case (op)
            OP_LOAD: begin
                div_d = (div_pi == '0) ? DIV_ONE : div_pi;
                cnt_d = '0;
            end
            OP_RUN: begin
                if (cnt_q == div_q - DIV_ONE) begin
                    cnt_d = '0;
                    en_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + DIV_ONE;
                end
            end
            OP_STEP: begin
                cnt_d = '0;
                en_d  = step_rise;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_pi or posedge reset_pi) begin
        if (reset_pi) begin
            div_q      <= RESET_DIV_Q;
            cnt_q      <= '0;
            en_q       <= 1'b0;
            en_count_q <= '0;
        end else begin
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            en_q       <= en_d;
            // Counts each pulse as it is issued, so the count and the pulse appear together.
            en_count_q <= en_count_q + CNT_WIDTH'(en_d);
        end
    end

    assign clk_en_po   = en_q;
    assign div_po      = div_q;
    assign en_count_po = en_count_q;

endmodule

// File: tb/tb_cpu_clken_gen.sv
// Self-checking bench for cpu_clken_gen: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_cpu_clken_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  mode = 2'b00;
    logic [31:0] div_in = 32'd0;
    logic        div_load = 1'b0;
    logic        step = 1'b0;
    logic        clk_en;
    logic [31:0] div_out;
    logic [15:0] en_count;

    int total = 0;
    int bad = 0;

    cpu_clken_gen dut (
        .clk_pi      (clk),
        .reset_pi    (reset),
        .mode_pi     (mode),
        .div_pi      (div_in),
        .div_load_pi (div_load),
        .step_pi     (step),
        .clk_en_po   (clk_en),
        .div_po      (div_out),
        .en_count_po (en_count)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // m_elapsed counts RUN edges since the last load or STEP cycle; a pulse falls on
    // every multiple of the divisor. m_pulses is the running total of pulses issued.
    logic [31:0]     m_div = 32'd1;
    longint unsigned m_elapsed = 0;
    logic            m_en = 1'b0;
    longint unsigned m_pulses = 0;
    logic            m_step_prev = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_div       = 32'd1;
            m_elapsed   = 0;
            m_en        = 1'b0;
            m_pulses    = 0;
            m_step_prev = 1'b0;
        end else begin
            if (div_load) begin
                m_div     = (div_in == 32'd0) ? 32'd1 : div_in;
                m_elapsed = 0;
                m_en      = 1'b0;
            end else if (mode == 2'b00) begin
                m_elapsed = m_elapsed + 1;
                m_en      = ((m_elapsed % longint'(m_div)) == 0);
            end else if (mode == 2'b01) begin
                m_elapsed = 0;
                m_en      = step && !m_step_prev;
            end else begin
                m_en = 1'b0;
            end
            if (m_en) m_pulses = m_pulses + 1;
            m_step_prev = step;
        end
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    logic chk_on = 1'b0;

    always @(negedge clk) begin
        if (chk_on && !reset) begin
            check("model_clk_en", 64'(clk_en), 64'(m_en));
            check("model_div", 64'(div_out), 64'(m_div));
            check("model_en_count", 64'(en_count), 64'(m_pulses[15:0]));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_div(input logic [31:0] d);
        div_in   = d;
        div_load = 1'b1;
        @(negedge clk);
        div_load = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] c0;
        int pulses;
        int guard;

        // Reset state
        cycles(2);
        check("reset_clk_en", 64'(clk_en), 64'd0);
        check("reset_div", 64'(div_out), 64'd1);
        check("reset_en_count", 64'(en_count), 64'd0);
        reset  = 1'b0;
        chk_on = 1'b1;

        // Default divisor 1 in RUN: enable every edge
        cycles(10);
        check("div1_clk_en", 64'(clk_en), 64'd1);
        check("div1_en_count", 64'(en_count), 64'd10);

        // Divisor 4: pulses on the 4th, 8th, 12th edges after the load edge
        load_div(32'd4);
        check("load4_clk_en", 64'(clk_en), 64'd0);
        check("load4_div", 64'(div_out), 64'd4);
        c0 = en_count;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            check("div4_pulse", 64'(clk_en), 64'((i % 4) == 0));
        end
        check("div4_en_count", 64'(en_count), 64'(c0 + 16'd3));

        // Divisor 0 is stored as 1
        load_div(32'd0);
        check("load0_div", 64'(div_out), 64'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("div0_clk_en", 64'(clk_en), 64'd1);
        end

        // STEP: high 5, low 2, high 1 -> two pulses
        mode = 2'b01;
        step = 1'b0;
        cycles(2);
        c0 = en_count;
        pulses = 0;
        step = 1'b1;
        for (int i = 0; i < 5; i++) begin @(negedge clk); pulses += int'(clk_en); end
        step = 1'b0;
        for (int i = 0; i < 2; i++) begin @(negedge clk); pulses += int'(clk_en); end
        step = 1'b1;
        @(negedge clk); pulses += int'(clk_en);
        step = 1'b0;
        for (int i = 0; i < 3; i++) begin @(negedge clk); pulses += int'(clk_en); end
        check("step_pulses", 64'(pulses), 64'd2);
        check("step_en_count", 64'(en_count), 64'(c0 + 16'd2));

        // Divisor 5: RUN 3, HALT 10, RUN -> pulse on the 2nd edge after resuming
        mode = 2'b00;
        load_div(32'd5);
        cycles(3);
        mode = 2'b10;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("halt_clk_en", 64'(clk_en), 64'd0);
        end
        mode = 2'b00;
        @(negedge clk);
        check("resume_edge1", 64'(clk_en), 64'd0);
        @(negedge clk);
        check("resume_edge2", 64'(clk_en), 64'd1);

        // Pulse counter wrap: reach 0xFFFF at divisor 1, one more pulse wraps to 0
        load_div(32'd1);
        guard = 0;
        while (m_pulses[15:0] != 16'hFFFF && guard < 70000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 70000) begin
            total++;
            bad++;
            $display("FAIL wrap_wait: count %0h never reached ffff", en_count);
        end
        check("count_ffff", 64'(en_count), 64'hFFFF);
        @(negedge clk);
        check("count_wrap", 64'(en_count), 64'd0);

        // Asynchronous reset mid-count with divisor 6
        load_div(32'd6);
        cycles(3);
        #2 reset = 1'b1;
        #1;
        check("async_rst_clk_en", 64'(clk_en), 64'd0);
        check("async_rst_div", 64'(div_out), 64'd1);
        check("async_rst_en_count", 64'(en_count), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Randomized traffic, checked every cycle by the model
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 7))
                0, 1, 2, 3: mode = 2'b00;
                4, 5:       mode = 2'b01;
                6:          mode = 2'b10;
                default:    mode = 2'b11;
            endcase
            step     = 1'($urandom_range(0, 1));
            div_load = ($urandom_range(0, 15) == 0);
            div_in   = 32'($urandom_range(0, 7));
            @(negedge clk);
        end
        div_load = 1'b0;
        cycles(2);

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
